// File: rtl/hilo_mdu_pkg.sv
// hilo_mdu_pkg
//   Shared definitions for the HI/LO multiply/divide unit: operation codes
//   (also used by the instruction decoder), FSM state encodings and the
//   fixed datapath widths.
package hilo_mdu_pkg;

   typedef enum logic [2:0] {
      MDU_MULT  = 3'd0,
      MDU_MULTU = 3'd1,
      MDU_DIV   = 3'd2,
      MDU_DIVU  = 3'd3,
      MDU_MTHI  = 3'd4,
      MDU_MTLO  = 3'd5
   } mdu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } mdu_state_e;

   localparam int unsigned XLEN  = 32;
   // Shared iteration register: [64:32] partial sum / partial remainder,
   // [31:0] multiplier bits still to consume / quotient bits being built.
   localparam int unsigned ACC_W = 65;
   localparam int unsigned CNT_W = 5;
   localparam logic [CNT_W-1:0] LAST_STEP = 5'd31;

endpackage

// File: rtl/hilo_mdu_step.sv
// hilo_mdu_step
//   Combinational single radix-2 iteration shared by multiply and divide.
//   Ports:
//     acc_i    [64:0] current iteration register
//     opnd_i   [31:0] multiplicand magnitude (multiply) or divisor magnitude (divide)
//     is_div_i        1 = restoring divide step, 0 = shift-add multiply step
//     acc_o    [64:0] iteration register after this step
module hilo_mdu_step
   import hilo_mdu_pkg::*;
(
   input  logic [ACC_W-1:0] acc_i,
   input  logic [XLEN-1:0]  opnd_i,
   input  logic             is_div_i,
   output logic [ACC_W-1:0] acc_o
);

   logic [XLEN:0]   sum;
   logic [XLEN:0]   rem_sh;
   logic [XLEN+1:0] diff;

   always_comb begin
      // Multiply: add the multiplicand when the current multiplier LSB is
      // set, then shift the whole register right. The upper half never
      // exceeds 33 bits, so the sum cannot overflow.
      sum    = acc_i[64:32] + {1'b0, opnd_i & {XLEN{acc_i[0]}}};
      // Divide: bring the next dividend bit into the partial remainder and
      // trial-subtract the divisor; the borrow bit decides the quotient bit.
      rem_sh = {acc_i[63:32], acc_i[31]};
      diff   = {1'b0, rem_sh} - {2'b00, opnd_i};
      if (is_div_i) begin
         if (diff[XLEN+1]) begin
            acc_o = {rem_sh, acc_i[30:0], 1'b0};
         end else begin
            acc_o = {diff[XLEN:0], acc_i[30:0], 1'b1};
         end
      end else begin
         acc_o = {1'b0, sum, acc_i[31:1]};
      end
   end

endmodule

// File: rtl/hilo_mdu.sv
// hilo_mdu
//   Iterative multiply/divide unit owning the HI/LO register pair.
//   MULT/MULTU/DIV/DIVU take 33 cycles (32 steps + sign fix);
//   MTHI/MTLO complete in a single cycle without asserting busy.
//   Ports:
//     clk          core clock, rising edge
//     rst_n        asynchronous active-low reset
//     start        issue request, sampled only when idle
//     op    [2:0]  operation code (mdu_op_e)
//     a     [31:0] rs operand: multiplicand / dividend / MTHI-MTLO data
//     b     [31:0] rt operand: multiplier / divisor
//     flush        abort in-flight operation, blocks a same-cycle start
//     busy         operation in flight (combinational from state)
//     done         one-cycle pulse when a multi-cycle op updates HI/LO
//     hi    [31:0] HI register
//     lo    [31:0] LO register
module hilo_mdu
   import hilo_mdu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   mdu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [XLEN-1:0]  opnd_q, opnd_d;
   logic             is_div_q, is_div_d;
   logic             neg_main_q, neg_main_d;  // negate product / quotient
   logic             neg_rem_q, neg_rem_d;    // negate remainder
   logic [XLEN-1:0]  hi_q, hi_d;
   logic [XLEN-1:0]  lo_q, lo_d;
   logic             done_q, done_d;

   logic [ACC_W-1:0] acc_step;
   logic             sgn_op;
   logic [63:0]      prod_fix;
   logic [XLEN-1:0]  quo_fix;
   logic [XLEN-1:0]  rem_fix;

   function automatic logic [XLEN-1:0] mag32(input logic [XLEN-1:0] x,
                                             input logic            is_signed);
      logic signed [XLEN-1:0] xs;
      xs = signed'(x);
      // 0x8000_0000 maps onto itself, which is exactly the 2^31 magnitude.
      return (is_signed && xs < 0) ? (~x + 32'd1) : x;
   endfunction

   function automatic logic [63:0] neg64(input logic [63:0] x, input logic en);
      return en ? (~x + 64'd1) : x;
   endfunction

   function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] x, input logic en);
      return en ? (~x + 32'd1) : x;
   endfunction

   hilo_mdu_step u_step (
      .acc_i    (acc_q),
      .opnd_i   (opnd_q),
      .is_div_i (is_div_q),
      .acc_o    (acc_step)
   );

   assign sgn_op   = (op == MDU_MULT) || (op == MDU_DIV);
   assign prod_fix = neg64(acc_q[63:0], neg_main_q);
   assign quo_fix  = neg32(acc_q[31:0], neg_main_q);
   assign rem_fix  = neg32(acc_q[63:32], neg_rem_q);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opnd_d     = opnd_q;
      is_div_d   = is_div_q;
      neg_main_d = neg_main_q;
      neg_rem_d  = neg_rem_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               case (op)
                  MDU_MTHI: hi_d = a;
                  MDU_MTLO: lo_d = a;
                  MDU_MULT, MDU_MULTU: begin
                     acc_d      = {33'd0, mag32(b, sgn_op)};
                     opnd_d     = mag32(a, sgn_op);
                     is_div_d   = 1'b0;
                     neg_main_d = sgn_op && (a[31] ^ b[31]);
                     neg_rem_d  = 1'b0;
                     cnt_d      = '0;
                     state_d    = S_CALC;
                  end
                  MDU_DIV, MDU_DIVU: begin
                     acc_d      = {33'd0, mag32(a, sgn_op)};
                     opnd_d     = mag32(b, sgn_op);
                     is_div_d   = 1'b1;
                     // A zero divisor yields an all-ones quotient from the
                     // magnitude datapath; leaving it un-negated keeps LO at
                     // 0xFFFF_FFFF and the remainder correction restores HI = a.
                     neg_main_d = sgn_op && (a[31] ^ b[31]) && (b != '0);
                     neg_rem_d  = sgn_op && a[31];
                     cnt_d      = '0;
                     state_d    = S_CALC;
                  end
                  default: ;
               endcase
            end
         end
         S_CALC: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d = acc_step;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == LAST_STEP) begin
                  state_d = S_FIX;
               end
            end
         end
         S_FIX: begin
            state_d = S_IDLE;
            if (!flush) begin
               if (is_div_q) begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end else begin
                  hi_d = prod_fix[63:32];
                  lo_d = prod_fix[31:0];
               end
               done_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         opnd_q     <= '0;
         is_div_q   <= 1'b0;
         neg_main_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opnd_q     <= opnd_d;
         is_div_q   <= is_div_d;
         neg_main_q <= neg_main_d;
         neg_rem_q  <= neg_rem_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: doc/hilo_mdu.md
# hilo_mdu

Multi-cycle multiply/divide unit owning the HI/LO register pair of the MIPS core. It consumes both register-file read operands (rs on `a`, rt on `b`) in the execute stage and runs MULT/MULTU/DIV/DIVU iteratively over 33 cycles while `busy` stalls the pipeline. MTHI/MTLO complete in one cycle. HI/LO feed MFHI/MFLO results back toward register-file writeback.

## Interface
- No parameters; widths fixed at 32 (operands) and 64 (HI:LO).
- `clk`  in  1  core clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue request; sampled only in IDLE.
- `op`  in  3  operation code; encodings in the shared header.
- `a`  in  32  rs operand; dividend, multiplicand, or MTHI/MTLO data.
- `b`  in  32  rt operand; divisor or multiplier.
- `flush`  in  1  abort in-flight operation (exception or branch squash).
- `busy`  out  1  high while an operation is in flight (state != IDLE); combinational from state.
- `done`  out  1  registered one-cycle pulse when HI/LO are updated by a multi-cycle op.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE with `start`:
  - MTHI: `hi <= a`. MTLO: `lo <= a`. Stay in IDLE; no `busy`, no `done`.
  - MULT/MULTU/DIV/DIVU: latch |a|, |b| (absolute values for the signed ops, raw values for unsigned), latch the result-sign flags, clear the 5-bit counter, go to CALC.
  - Any other `op` is a no-op.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, 32-bit quotient and 33-bit partial remainder.
  - After the 32nd step (counter wraps 31→0), go to FIX.
- FIX: apply sign correction, write HI/LO, pulse `done`, return to IDLE.
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - HI = product[63:32] / remainder; LO = product[31:0] / quotient.
- Divide by zero (`b == 0`, signed or unsigned): normal latency; HI = `a`, LO = 32'hFFFF_FFFF.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0. This falls out of the magnitude datapath and needs no special case.
- `start` while busy is ignored. The pipeline must hold the instruction until `busy` is low.
- `flush` in CALC or FIX: return to IDLE next edge; HI/LO unchanged; no `done`. `flush` takes priority over FIX completion. In IDLE, `flush` blocks a same-cycle `start`.

## Timing
- Multi-cycle issue at edge 0, then:
  - Edges 1–32: iteration steps in CALC.
  - Edge 33: in FIX; writes HI/LO, sets `done`, returns to IDLE.
  - `busy` is high from after edge 0 until after edge 33.
  - `done` is high between edges 33 and 34.
  - A new `start` is accepted at edge 34 at the earliest, i.e. the cycle `busy` is low.
- MTHI/MTLO: HI/LO visible the cycle after the edge.
- Reset (async, any state, including mid-CALC): state IDLE, `hi` = `lo` = 0, `busy` = 0, `done` = 0, counter = 0, internal accumulators cleared.

## Structure
- Shared header `mdu_defs.vh`: op codes MDU_MULT=3'd0, MDU_MULTU=3'd1, MDU_DIV=3'd2, MDU_DIVU=3'd3, MDU_MTHI=3'd4, MDU_MTLO=3'd5, plus state encodings. The decoder includes the same header.
- One natural sub-module, `mdu_step`: a combinational single-iteration datapath that takes the accumulator/remainder and mode and returns the next value. `hilo_mdu` keeps the FSM, counter, sign handling and HI/LO registers.

## Test plan
- MULT 0xFFFF_FFFF × 2 → after 33 cycles HI=0xFFFF_FFFF, LO=0xFFFF_FFFE, one `done` pulse; MULTU with same operands → HI=0x0000_0001, LO=0xFFFF_FFFE.
- DIV −7 / 2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF; DIVU 100 / 7 → LO=0x0000_000E, HI=0x0000_0002.
- DIV 0x8000_0000 / 0xFFFF_FFFF → LO=0x8000_0000, HI=0; DIVU 5 / 0 → HI=5, LO=0xFFFF_FFFF.
- MTHI 0x1234_5678, then MTLO 0x9ABC_DEF0 on consecutive cycles → both visible next cycle; `busy` never asserts.
- MULT started, second `start` (DIVU) at cycle 5 → ignored, MULT result correct; `flush` at cycle 10 of another op → IDLE next cycle, HI/LO keep prior values, no `done`.
- `rst_n` low at cycle 17 of a DIV → HI=LO=0, `busy`=0 immediately; after release, MULTU 3×4 → LO=12.
